// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline hazard controller: forward-select codes,
// controller states and the scoreboard slot layout.
package mips_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_wr;
    logic                  mem_rd;
    logic [REG_ADDR_W-1:0] dst;
  } sb_slot_t;

  localparam sb_slot_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-operand comparator: matches one decode source register against the EX and
// MEM scoreboard slots and yields the forward select plus a load-use hit.
module hazard_fwd_cmp
  import mips_pipe_pkg::*;
#(
  parameter int ZERO_REG_HARD = 1
) (
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_used,
  input  sb_slot_t              i_ex,
  input  sb_slot_t              i_mem,
  output logic [1:0]            o_fwd_sel,
  output logic                  o_load_use
);

  logic w_addr_ok;
  logic w_ex_hit;
  logic w_mem_hit;

  assign w_addr_ok = i_used & ((ZERO_REG_HARD == 0) || (i_addr != '0));
  assign w_ex_hit  = w_addr_ok & i_ex.valid  & i_ex.reg_wr  & (i_ex.dst  == i_addr);
  assign w_mem_hit = w_addr_ok & i_mem.valid & i_mem.reg_wr & (i_mem.dst == i_addr);

  // The EX slot holds the youngest producer, so it takes priority over MEM.
  always_comb begin
    o_fwd_sel = FWD_RF;
    if (w_ex_hit)       o_fwd_sel = FWD_EX;
    else if (w_mem_hit) o_fwd_sel = FWD_MEM;
  end

  assign o_load_use = w_ex_hit & i_ex.mem_rd;

endmodule

// File: rtl/mips_hazard_ctrl.sv
// Decode-side hazard controller: EX/MEM scoreboard, forwarding, load-use stalls
// and redirect flush bubbles. HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module mips_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 2,
  parameter int ZERO_REG_HARD = 1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_rd,
  input  logic                  ex_redirect,
  output logic                  En_Pipeline,
  output logic                  flush,
  output logic                  F_Read_Reg_En,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_t r_state;
  hz_state_t w_next_state;
  logic [2:0] r_bub_cnt;
  logic [2:0] w_next_cnt;
  sb_slot_t  r_ex;
  sb_slot_t  r_mem;

  logic w_lu_a;
  logic w_lu_b;
  logic w_stall;
  logic w_flush;

  hazard_fwd_cmp #(.ZERO_REG_HARD(ZERO_REG_HARD)) u_cmp_a (
    .i_addr     (id_rs),
    .i_used     (id_rs_used),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .o_fwd_sel  (fwd_sel_a),
    .o_load_use (w_lu_a)
  );

  hazard_fwd_cmp #(.ZERO_REG_HARD(ZERO_REG_HARD)) u_cmp_b (
    .i_addr     (id_rt),
    .i_used     (id_rt_used),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .o_fwd_sel  (fwd_sel_b),
    .o_load_use (w_lu_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_bub_cnt <= '0;
    end else begin
      r_state   <= w_next_state;
      r_bub_cnt <= w_next_cnt;
    end
  end

  // The redirect cycle is itself the first bubble, so FLUSH lasts FLUSH_CYCLES-1 cycles.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_bub_cnt;
    case (r_state)
      ST_RUN: begin
        if (ex_redirect && (FLUSH_CYCLES > 1)) begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = FLUSH_RELOAD;
        end
      end
      ST_FLUSH: begin
        if (ex_redirect) begin
          w_next_cnt   = FLUSH_RELOAD;
          w_next_state = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (r_bub_cnt <= 3'd1) begin
          w_next_cnt   = '0;
          w_next_state = ST_RUN;
        end else begin
          w_next_cnt   = r_bub_cnt - 3'd1;
        end
      end
      default: begin
        w_next_state = ST_RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    w_stall       = (r_state == ST_RUN) & ~ex_redirect & (w_lu_a | w_lu_b);
    w_flush       = w_stall | ex_redirect | (r_state == ST_FLUSH);
    En_Pipeline   = ~w_stall;
    F_Read_Reg_En = ~w_stall;
    flush         = w_flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex  <= SB_BUBBLE;
      r_mem <= SB_BUBBLE;
    end else begin
      r_mem <= r_ex;
      if (w_flush) r_ex <= SB_BUBBLE;
      else         r_ex <= '{valid: 1'b1, reg_wr: id_reg_wr, mem_rd: id_mem_rd, dst: id_dst};
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Stall bubbles are counted separately, so flush_cnt covers redirect bubbles only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !w_stall && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
